// File: rtl/int_gateway_plic.sv
// int_gateway_plic: one-shot level gateway with priority arbiter and claim/complete handshake for five sources
module int_gateway_plic (
  input  logic        clock,
  input  logic        reset,
  input  logic        auto_int_in_0,
  input  logic        auto_int_in_1,
  input  logic        auto_int_in_2,
  input  logic        auto_int_in_3,
  input  logic        auto_int_in_4,
  input  logic [4:0]  io_enable,
  input  logic [14:0] io_prio,
  input  logic [2:0]  io_threshold,
  output logic        io_irq,
  input  logic        io_claim_valid,
  output logic [2:0]  io_claim_id,
  input  logic        io_complete_valid,
  input  logic [2:0]  io_complete_id
);
  logic [4:0] src, sync1, sync2, pending, inflight, cand, claim_oh, done_oh;
  logic [2:0] best_id, best_p;
  assign src = {auto_int_in_4, auto_int_in_3, auto_int_in_2, auto_int_in_1, auto_int_in_0};
  // ascending scan with strict compare keeps the lowest ID on priority ties
  always_comb begin
    cand = '0;
    best_id = '0;
    best_p = '0;
    claim_oh = '0;
    done_oh = '0;
    for (int i = 0; i < 5; i++) begin
      cand[i] = pending[i] & io_enable[i] & (io_prio[3*i +: 3] > io_threshold);
      if (cand[i] && io_prio[3*i +: 3] > best_p) begin
        best_p = io_prio[3*i +: 3];
        best_id = 3'(i + 1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      claim_oh[i] = io_claim_valid && best_id == 3'(i + 1);
      done_oh[i] = io_complete_valid && io_complete_id == 3'(i + 1);
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      pending <= '0;
      inflight <= '0;
      io_irq <= 1'b0;
      io_claim_id <= '0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
      pending <= (pending | (sync2 & ~inflight)) & ~claim_oh;
      inflight <= (inflight | claim_oh) & ~done_oh;
      io_irq <= |cand;
      io_claim_id <= io_claim_valid ? best_id : io_claim_id;
    end
endmodule

// File: tb/tb_int_gateway_plic.sv
// tb_int_gateway_plic: directed stimulus with a claim-result scoreboard checked by an independent monitor
module tb_int_gateway_plic;
  logic        clock = 0, reset = 1;
  logic [4:0]  src = '0, io_enable = '1;
  logic [14:0] io_prio = '0;
  logic [2:0]  io_threshold = 3'd2, io_claim_id, io_complete_id = '0;
  logic        io_irq, io_claim_valid = 0, io_complete_valid = 0;
  int checks = 0, failures = 0;
  logic [2:0] exp_q[$];

  int_gateway_plic dut (
    .clock(clock), .reset(reset),
    .auto_int_in_0(src[0]), .auto_int_in_1(src[1]), .auto_int_in_2(src[2]),
    .auto_int_in_3(src[3]), .auto_int_in_4(src[4]),
    .io_enable(io_enable), .io_prio(io_prio), .io_threshold(io_threshold),
    .io_irq(io_irq), .io_claim_valid(io_claim_valid), .io_claim_id(io_claim_id),
    .io_complete_valid(io_complete_valid), .io_complete_id(io_complete_id)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_prio(input int id, input logic [2:0] p);
    io_prio[3*(id-1) +: 3] = p;
  endtask

  task automatic claim(input logic [2:0] exp);
    exp_q.push_back(exp);
    io_claim_valid = 1;
    @(negedge clock);
    io_claim_valid = 0;
  endtask

  task automatic complete(input logic [2:0] id);
    io_complete_valid = 1;
    io_complete_id = id;
    @(negedge clock);
    io_complete_valid = 0;
  endtask

  // monitor: every edge that saw a claim strobe must present the next queued ID
  initial begin
    logic cv;
    logic [2:0] e;
    forever begin
      @(posedge clock);
      cv = io_claim_valid;
      #1;
      if (cv) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL claim_unexpected got=%0d expected=none", io_claim_id);
        end else begin
          e = exp_q.pop_front();
          if (io_claim_id !== e) begin
            failures++;
            $display("FAIL claim_id got=%0d expected=%0d", io_claim_id, e);
          end
        end
      end
    end
  end

  initial begin
    wait_n(2);
    chk("reset_irq", {2'b0, io_irq}, 0);
    chk("reset_claim_id", io_claim_id, 0);
    reset = 0;
    // single source latency, claim, deassert
    set_prio(3, 5);
    src[2] = 1;
    wait_n(3);
    chk("t1_irq_edge3", {2'b0, io_irq}, 0);
    wait_n(1);
    chk("t1_irq_edge4", {2'b0, io_irq}, 1);
    claim(3);
    chk("t1_irq_claim_edge", {2'b0, io_irq}, 1);
    wait_n(1);
    chk("t1_irq_after", {2'b0, io_irq}, 0);
    src[2] = 0;
    wait_n(3);
    chk("t1_claim_hold", io_claim_id, 3);
    complete(3);
    wait_n(4);
    chk("t1_no_repend", {2'b0, io_irq}, 0);
    // tie at equal priority, claim held three cycles
    io_prio = '0;
    set_prio(1, 6);
    set_prio(4, 6);
    src[0] = 1;
    src[3] = 1;
    wait_n(4);
    chk("t2_irq", {2'b0, io_irq}, 1);
    exp_q.push_back(1);
    exp_q.push_back(4);
    exp_q.push_back(0);
    io_claim_valid = 1;
    wait_n(3);
    io_claim_valid = 0;
    chk("t2_irq_after", {2'b0, io_irq}, 0);
    src[0] = 0;
    src[3] = 0;
    wait_n(3);
    complete(1);
    complete(4);
    // one-cycle pulse: no re-pend after complete
    io_prio = '0;
    set_prio(2, 4);
    src[1] = 1;
    wait_n(1);
    src[1] = 0;
    wait_n(3);
    chk("t3_pulse_irq", {2'b0, io_irq}, 1);
    claim(2);
    wait_n(3);
    complete(2);
    wait_n(4);
    chk("t3_pulse_no_repend", {2'b0, io_irq}, 0);
    claim(0);
    // held high through complete: re-pends
    src[1] = 1;
    wait_n(4);
    chk("t3_held_irq", {2'b0, io_irq}, 1);
    claim(2);
    wait_n(3);
    chk("t3_held_inflight", {2'b0, io_irq}, 0);
    complete(2);
    wait_n(1);
    chk("t3_repend_early", {2'b0, io_irq}, 0);
    wait_n(1);
    chk("t3_repend_irq", {2'b0, io_irq}, 1);
    claim(2);
    src[1] = 0;
    wait_n(3);
    complete(2);
    // threshold masking and ignored completes
    io_prio = '0;
    set_prio(5, 7);
    src[4] = 1;
    wait_n(4);
    chk("t5_irq", {2'b0, io_irq}, 1);
    io_threshold = 7;
    wait_n(1);
    chk("t5_masked", {2'b0, io_irq}, 0);
    claim(0);
    complete(7);
    complete(2);
    complete(5);
    io_threshold = 2;
    wait_n(1);
    chk("t5_restored", {2'b0, io_irq}, 1);
    claim(5);
    src[4] = 0;
    wait_n(3);
    complete(5);
    wait_n(2);
    claim(0);
    chk("t4_idle_irq", {2'b0, io_irq}, 0);
    // disabled source still latches pending
    io_prio = '0;
    set_prio(1, 3);
    io_enable = 5'b11110;
    src[0] = 1;
    wait_n(4);
    chk("t6_disabled_irq", {2'b0, io_irq}, 0);
    claim(0);
    io_enable = '1;
    wait_n(1);
    chk("t6_enabled_irq", {2'b0, io_irq}, 1);
    claim(1);
    src[0] = 0;
    wait_n(3);
    complete(1);
    // reset mid-operation with one in flight and one pending
    set_prio(2, 3);
    src[0] = 1;
    wait_n(4);
    claim(1);
    src[1] = 1;
    wait_n(4);
    chk("t7_pre_irq", {2'b0, io_irq}, 1);
    chk("t7_pre_claim", io_claim_id, 1);
    #2 reset = 1;
    #1;
    chk("t7_rst_irq", {2'b0, io_irq}, 0);
    chk("t7_rst_claim", io_claim_id, 0);
    wait_n(2);
    reset = 0;
    wait_n(3);
    chk("t7_repend_edge3", {2'b0, io_irq}, 0);
    wait_n(1);
    chk("t7_repend_edge4", {2'b0, io_irq}, 1);
    claim(1);
    claim(2);
    wait_n(2);
    chk("scoreboard_empty", 3'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
